class_score_accumulator: RTL and testbench

// - Output-layer MAC stage. Streams one input-activation vector against three per-class weight streams.
// - Produces three 32-bit unsigned class scores; these are the num1/num2/num3 inputs of the argmax comparator downstream.
// - Scores are clamped non-negative because the downstream comparator compares unsigned.

---
 rtl/nn_pkg.sv | 25 ++
 rtl/class_score_accumulator_if.sv | 32 +++
 rtl/score_mac_lane.sv | 55 +++++
 rtl/class_score_accumulator.sv | 123 ++++++++++++
 tb/tb_class_score_accumulator.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared widths, FSM state type and score saturation for the output-layer MAC stage.
package nn_pkg;

  localparam int unsigned ACT_W   = 16;
  localparam int unsigned W_W     = 16;
  localparam int unsigned ACC_W   = 48;
  localparam int unsigned SCORE_W = 32;
  localparam int unsigned N_CLASS = 3;
  // Unsigned activation widened by a zero sign bit, times a signed weight.
  localparam int unsigned PROD_W  = ACT_W + 1 + W_W;

  typedef enum logic [1:0] {ACC, DRAIN, SAT, OUT} state_e;

  // Clamp a signed accumulator into the unsigned score range.
  function automatic logic [SCORE_W-1:0] sat_u32(input logic signed [ACC_W-1:0] acc);
    if (acc[ACC_W-1]) begin
      return '0;
    end else if (|acc[ACC_W-2:SCORE_W]) begin
      return '1;
    end else begin
      return acc[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/class_score_accumulator_if.sv
// Beat input stream, per-vector biases and score output handshake of the accumulator.
interface class_score_accumulator_if;
  import nn_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic        [ACT_W-1:0]   in_data;
  logic signed [W_W-1:0]     in_w0;
  logic signed [W_W-1:0]     in_w1;
  logic signed [W_W-1:0]     in_w2;
  logic                      in_last;
  logic signed [SCORE_W-1:0] bias0;
  logic signed [SCORE_W-1:0] bias1;
  logic signed [SCORE_W-1:0] bias2;
  logic                      out_valid;
  logic                      out_ready;
  logic        [SCORE_W-1:0] score0;
  logic        [SCORE_W-1:0] score1;
  logic        [SCORE_W-1:0] score2;
  logic                      len_err;

  modport master (
    output in_valid, in_data, in_w0, in_w1, in_w2, in_last, bias0, bias1, bias2, out_ready,
    input  in_ready, out_valid, score0, score1, score2, len_err
  );

  modport slave (
    input  in_valid, in_data, in_w0, in_w1, in_w2, in_last, bias0, bias1, bias2, out_ready,
    output in_ready, out_valid, score0, score1, score2, len_err
  );

endinterface

// File: rtl/score_mac_lane.sv
// One class lane: registered product, bias-seeded accumulator and clamped score register.
module score_mac_lane
  import nn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      beat,
  input  logic                      load,
  input  logic                      sat_en,
  input  logic        [ACT_W-1:0]   act,
  input  logic signed [W_W-1:0]     w,
  input  logic signed [SCORE_W-1:0] bias,
  output logic        [SCORE_W-1:0] score
);

  logic signed [PROD_W-1:0]  prod_q;
  logic                      prod_v_q;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic        [SCORE_W-1:0] score_q;

  assign prod_ext = ACC_W'(prod_q);

  // The first beat of a vector reseeds from the bias; any product still in flight is folded in.
  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = ACC_W'(bias) + (prod_v_q ? prod_ext : '0);
    end else if (prod_v_q) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      score_q  <= '0;
    end else begin
      prod_v_q <= beat;
      if (beat) begin
        prod_q <= $signed({1'b0, act}) * w;
      end
      acc_q <= acc_d;
      if (sat_en) begin
        score_q <= sat_u32(acc_q);
      end
    end
  end

  assign score = score_q;

endmodule

// File: rtl/class_score_accumulator.sv
// Output-layer MAC stage: three class lanes sharing one beat counter, FSM and handshakes.
module class_score_accumulator
  import nn_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 256
) (
  input logic                      clk,
  input logic                      rst,
  class_score_accumulator_if.slave bus
);

  localparam int unsigned CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             first_q;
  logic             end_cnt_q;
  logic             len_err_q;
  logic             acc_st;
  logic             beat;
  logic             load;
  logic             at_max;
  logic             sat_en;
  logic             out_xfer;

  // in_ready is a pure state decode so no input can reach it combinationally.
  assign acc_st       = (state_q == ACC);
  assign bus.in_ready = acc_st;
  assign beat         = bus.in_valid & acc_st;
  assign load         = beat & first_q;
  assign at_max       = (cnt_q == CNT_W'(MAX_BEATS - 1));
  assign out_xfer     = (state_q == OUT) & bus.out_ready;
  assign bus.len_err  = len_err_q;

  always_comb begin
    state_d       = state_q;
    bus.out_valid = 1'b0;
    sat_en        = 1'b0;
    unique case (state_q)
      ACC: begin
        if (beat && (bus.in_last || at_max)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = SAT;
      SAT: begin
        sat_en  = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      end_cnt_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (beat) begin
        cnt_q     <= cnt_q + 1'b1;
        first_q   <= 1'b0;
        // Only the final beat's value survives: set when the count, not in_last, ended it.
        end_cnt_q <= ~bus.in_last;
      end
      if (sat_en) begin
        len_err_q <= end_cnt_q;
      end
      if (out_xfer) begin
        cnt_q     <= '0;
        first_q   <= 1'b1;
        len_err_q <= 1'b0;
      end
    end
  end

  score_mac_lane u_lane0 (
    .clk    (clk),
    .rst    (rst),
    .beat   (beat),
    .load   (load),
    .sat_en (sat_en),
    .act    (bus.in_data),
    .w      (bus.in_w0),
    .bias   (bus.bias0),
    .score  (bus.score0)
  );

  score_mac_lane u_lane1 (
    .clk    (clk),
    .rst    (rst),
    .beat   (beat),
    .load   (load),
    .sat_en (sat_en),
    .act    (bus.in_data),
    .w      (bus.in_w1),
    .bias   (bus.bias1),
    .score  (bus.score1)
  );

  score_mac_lane u_lane2 (
    .clk    (clk),
    .rst    (rst),
    .beat   (beat),
    .load   (load),
    .sat_en (sat_en),
    .act    (bus.in_data),
    .w      (bus.in_w2),
    .bias   (bus.bias2),
    .score  (bus.score2)
  );

endmodule

// File: tb/tb_class_score_accumulator.sv
// Directed bench: a default build and a MAX_BEATS=4 build share one stimulus set, selected by sel.
module tb_class_score_accumulator;
  import nn_pkg::*;

  localparam int Budget = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  class_score_accumulator_if bus_a ();
  class_score_accumulator_if bus_b ();

  logic        sel;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [15:0] in_data;
  logic [15:0] w0;
  logic [15:0] w1;
  logic [15:0] w2;
  logic [31:0] b0;
  logic [31:0] b1;
  logic [31:0] b2;

  assign bus_a.in_valid  = in_valid & ~sel;
  assign bus_b.in_valid  = in_valid & sel;
  assign bus_a.out_ready = out_ready & ~sel;
  assign bus_b.out_ready = out_ready & sel;
  assign bus_a.in_data   = in_data;
  assign bus_b.in_data   = in_data;
  assign bus_a.in_w0     = w0;
  assign bus_b.in_w0     = w0;
  assign bus_a.in_w1     = w1;
  assign bus_b.in_w1     = w1;
  assign bus_a.in_w2     = w2;
  assign bus_b.in_w2     = w2;
  assign bus_a.in_last   = in_last;
  assign bus_b.in_last   = in_last;
  assign bus_a.bias0     = b0;
  assign bus_b.bias0     = b0;
  assign bus_a.bias1     = b1;
  assign bus_b.bias1     = b1;
  assign bus_a.bias2     = b2;
  assign bus_b.bias2     = b2;

  logic        in_ready_m;
  logic        out_valid_m;
  logic        len_err_m;
  logic [31:0] s0_m;
  logic [31:0] s1_m;
  logic [31:0] s2_m;

  assign in_ready_m  = sel ? bus_b.in_ready  : bus_a.in_ready;
  assign out_valid_m = sel ? bus_b.out_valid : bus_a.out_valid;
  assign len_err_m   = sel ? bus_b.len_err   : bus_a.len_err;
  assign s0_m        = sel ? bus_b.score0    : bus_a.score0;
  assign s1_m        = sel ? bus_b.score1    : bus_a.score1;
  assign s2_m        = sel ? bus_b.score2    : bus_a.score2;

  class_score_accumulator dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  class_score_accumulator #(.MAX_BEATS(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    bit          sel;
    int          n;
    bit          last_fin;
    logic [15:0] act [4];
    logic [15:0] w0 [4];
    logic [15:0] w1 [4];
    logic [15:0] w2 [4];
    logic [31:0] b0;
    logic [31:0] b1;
    logic [31:0] b2;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    bit          elen;
  } vec_t;

  vec_t v [8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive_beat(input logic [15:0] a, input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] x2, input bit last, output int waited);
    logic rdy;
    in_valid = 1'b1;
    in_data  = a;
    w0       = x0;
    w1       = x1;
    w2       = x2;
    in_last  = last;
    waited   = 0;
    rdy      = 1'b0;
    while (!rdy && waited < Budget) begin
      rdy = in_ready_m;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no in_ready, want a beat accepted within %0d cycles",
               Budget);
    end
  endtask

  // Entered #1 after the edge that took the last beat.
  task automatic finish_vec(input int i);
    int waited;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_out_valid_T+1", i), {31'd0, out_valid_m}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_out_valid_T+2", i), {31'd0, out_valid_m}, 32'd1);
    waited = 0;
    while (!out_valid_m && waited < Budget) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("v%0d_score0", i), s0_m, v[i].e0);
    chk($sformatf("v%0d_score1", i), s1_m, v[i].e1);
    chk($sformatf("v%0d_score2", i), s2_m, v[i].e2);
    chk($sformatf("v%0d_len_err", i), {31'd0, len_err_m}, {31'd0, v[i].elen});
  endtask

  task automatic run_vec(input int i);
    int waited;
    sel = v[i].sel;
    b0  = v[i].b0;
    b1  = v[i].b1;
    b2  = v[i].b2;
    for (int b = 0; b < v[i].n; b++) begin
      drive_beat(v[i].act[b], v[i].w0[b], v[i].w1[b], v[i].w2[b],
                 (b == v[i].n - 1) && v[i].last_fin, waited);
    end
    finish_vec(i);
  endtask

  task automatic take_out(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_ov_cleared"}, {31'd0, out_valid_m}, 32'd0);
    chk({name, "_len_err_cleared"}, {31'd0, len_err_m}, 32'd0);
    chk({name, "_in_ready_back"}, {31'd0, in_ready_m}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion within 200000 time units");
    $fatal(1);
  end

  initial begin
    int waited;

    v[0] = '{sel: 0, n: 3, last_fin: 1,
             act: '{16'd1, 16'd2, 16'd3, 16'd0}, w0: '{16'd1, 16'd1, 16'd1, 16'd0},
             w1: '{16'd2, 16'd0, 16'd0, 16'd0}, w2: '{16'd0, 16'd0, 16'd5, 16'd0},
             b0: 32'd0, b1: 32'd0, b2: 32'd0, e0: 32'd6, e1: 32'd2, e2: 32'd15, elen: 0};
    v[1] = '{sel: 0, n: 1, last_fin: 1,
             act: '{16'd1, 16'd0, 16'd0, 16'd0}, w0: '{16'hFFFF, 16'd0, 16'd0, 16'd0},
             w1: '{16'd3, 16'd0, 16'd0, 16'd0}, w2: '{16'd0, 16'd0, 16'd0, 16'd0},
             b0: 32'hFFFF_FF9C, b1: 32'd7, b2: 32'd0, e0: 32'd0, e1: 32'd10, e2: 32'd0,
             elen: 0};
    v[2] = '{sel: 0, n: 3, last_fin: 1,
             act: '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0}, w0: '{16'd0, 16'd0, 16'd0, 16'd0},
             w1: '{16'd0, 16'd0, 16'd0, 16'd0}, w2: '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd0},
             b0: 32'd0, b1: 32'd0, b2: 32'd0, e0: 32'd0, e1: 32'd0, e2: 32'hFFFF_FFFF,
             elen: 0};
    v[3] = '{sel: 0, n: 2, last_fin: 1,
             act: '{16'd10, 16'd20, 16'd0, 16'd0}, w0: '{16'hFFFD, 16'd5, 16'd0, 16'd0},
             w1: '{16'd100, 16'hFFFF, 16'd0, 16'd0}, w2: '{16'd7, 16'd7, 16'd0, 16'd0},
             b0: 32'd50, b1: 32'hFFFF_FFFB, b2: 32'd1000, e0: 32'd120, e1: 32'd975,
             e2: 32'd1210, elen: 0};
    v[4] = '{sel: 1, n: 4, last_fin: 0,
             act: '{16'd1, 16'd1, 16'd1, 16'd1}, w0: '{16'd1, 16'd2, 16'd3, 16'd4},
             w1: '{16'd0, 16'd0, 16'd0, 16'd0}, w2: '{16'd0, 16'd0, 16'd0, 16'd0},
             b0: 32'd0, b1: 32'd0, b2: 32'd0, e0: 32'd10, e1: 32'd0, e2: 32'd0, elen: 1};
    v[5] = '{sel: 1, n: 4, last_fin: 1,
             act: '{16'd1, 16'd1, 16'd1, 16'd1}, w0: '{16'd1, 16'd2, 16'd3, 16'd4},
             w1: '{16'd1, 16'd1, 16'd1, 16'd1}, w2: '{16'd0, 16'd0, 16'd0, 16'd0},
             b0: 32'd0, b1: 32'd0, b2: 32'd9, e0: 32'd10, e1: 32'd4, e2: 32'd9, elen: 0};
    v[6] = '{sel: 1, n: 1, last_fin: 1,
             act: '{16'd4, 16'd0, 16'd0, 16'd0}, w0: '{16'd5, 16'd0, 16'd0, 16'd0},
             w1: '{16'd0, 16'd0, 16'd0, 16'd0}, w2: '{16'd0, 16'd0, 16'd0, 16'd0},
             b0: 32'd0, b1: 32'd0, b2: 32'd0, e0: 32'd20, e1: 32'd0, e2: 32'd0, elen: 0};
    v[7] = '{sel: 0, n: 1, last_fin: 1,
             act: '{16'd2, 16'd0, 16'd0, 16'd0}, w0: '{16'd3, 16'd0, 16'd0, 16'd0},
             w1: '{16'd0, 16'd0, 16'd0, 16'd0}, w2: '{16'd0, 16'd0, 16'd0, 16'd0},
             b0: 32'd1, b1: 32'd0, b2: 32'd0, e0: 32'd7, e1: 32'd0, e2: 32'd0, elen: 0};

    sel       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    w0        = '0;
    w1        = '0;
    w2        = '0;
    b0        = '0;
    b1        = '0;
    b2        = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid_m}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_m}, 32'd1);
    chk("rst_score0", s0_m, 32'd0);
    chk("rst_score1", s1_m, 32'd0);
    chk("rst_score2", s2_m, 32'd0);
    chk("rst_len_err", {31'd0, len_err_m}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      run_vec(i);
      take_out($sformatf("v%0d", i));
    end

    // Forced end on the short build, then hold the result with a beat waiting upstream.
    run_vec(4);
    in_valid = 1'b1;
    in_data  = v[6].act[0];
    w0       = v[6].w0[0];
    w1       = v[6].w1[0];
    w2       = v[6].w2[0];
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold%0d_score0", c), s0_m, 32'd10);
      chk($sformatf("hold%0d_len_err", c), {31'd0, len_err_m}, 32'd1);
      chk($sformatf("hold%0d_in_ready", c), {31'd0, in_ready_m}, 32'd0);
      chk($sformatf("hold%0d_out_valid", c), {31'd0, out_valid_m}, 32'd1);
    end
    take_out("hold");
    drive_beat(v[6].act[0], v[6].w0[0], v[6].w1[0], v[6].w2[0], 1'b1, waited);
    chk("hold_next_accept_cycles", 32'(waited), 32'd1);
    finish_vec(6);
    take_out("v6");

    run_vec(5);
    take_out("v5");

    // Abandon a vector mid-stream; the next one must see none of its partial sum.
    sel = 1'b0;
    b0  = 32'd0;
    b1  = 32'd0;
    b2  = 32'd0;
    drive_beat(16'd100, 16'd100, 16'd100, 16'd100, 1'b0, waited);
    drive_beat(16'd100, 16'd100, 16'd100, 16'd100, 1'b0, waited);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid_m}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready_m}, 32'd1);
    chk("midrst_score0", s0_m, 32'd0);
    chk("midrst_score1", s1_m, 32'd0);
    chk("midrst_score2", s2_m, 32'd0);
    chk("midrst_len_err", {31'd0, len_err_m}, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_output", {31'd0, out_valid_m}, 32'd0);
    run_vec(7);
    take_out("v7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
